// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: FSM states, requester ids, data field slices and parameter defaults for the I2C arbiter
package i2c_arb_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT_END, ST_WAIT_LOW, ST_GAP} state_t;
  localparam int REQ_BOOT = 0;
  localparam int REQ_RT = 1;
  localparam int DEV_MSB = 31;
  localparam int DEV_LSB = 24;
  localparam int REG_MSB = 23;
  localparam int REG_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;
  localparam int MAX_RETRY_DEF = 2;
  localparam int TIMEOUT_DEF = 1023;
  localparam int GAP_DEF = 2;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant (req/acc in, one-hot gnt out); ties go to the requester not served last
module rr_arbiter2 import i2c_arb_pkg::*; (
  input  logic       clock_i2c,
  input  logic       camera_rstn,
  input  logic [1:0] req,
  input  logic       acc,
  output logic [1:0] gnt
);
  logic last;
  always_comb begin
    gnt[REQ_BOOT] = req[REQ_BOOT] & (~req[REQ_RT] | last);
    gnt[REQ_RT] = req[REQ_RT] & (~req[REQ_BOOT] | ~last);
  end
  // last=1 out of reset so requester 0 wins the first tie
  always_ff @(posedge clock_i2c or negedge camera_rstn)
    if (!camera_rstn) last <= 1'b1;
    else if (acc) last <= gnt[REQ_RT];
endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C engine (i2c_data/start/tr_end/ack) by two requesters (req_valid/req_ready/rsp_done/rsp_err) with timeout, retry and gap
module i2c_arbiter import i2c_arb_pkg::*; #(
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic        clock_i2c,
  input  logic        camera_rstn,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_done,
  output logic        rsp_err,
  output logic [31:0] i2c_data,
  output logic        start,
  input  logic        tr_end,
  input  logic        ack,
  output logic        busy,
  output logic        grant_id
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(GAP + 1);
  state_t state, state_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [31:0] i2c_data_d;
  logic [1:0] gnt, req_ready_d, rsp_done_d;
  logic ok, ok_d, pend, pend_d, acc, rsp_err_d, start_d, busy_d, grant_id_d;
  rr_arbiter2 u_arb (.clock_i2c, .camera_rstn, .req(req_valid), .acc, .gnt);
  always_comb begin
    state_d = state;
    tcnt_d = tcnt;
    rcnt_d = rcnt;
    gcnt_d = gcnt;
    ok_d = ok;
    pend_d = pend;
    i2c_data_d = i2c_data;
    grant_id_d = grant_id;
    start_d = start;
    busy_d = busy;
    req_ready_d = '0;
    rsp_done_d = '0;
    rsp_err_d = 1'b0;
    acc = 1'b0;
    case (state)
      ST_IDLE: if (|req_valid) begin
        acc = 1'b1;
        req_ready_d = gnt;
        grant_id_d = gnt[REQ_RT];
        i2c_data_d = gnt[REQ_RT] ? req1_data : req0_data;
        rcnt_d = '0;
        busy_d = 1'b1;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        start_d = 1'b1;
        tcnt_d = '0;
        state_d = ST_WAIT_END;
      end
      // a tr_end arriving on the same cycle as the timeout still counts as the engine's answer
      ST_WAIT_END: begin
        tcnt_d = tcnt == TW'(TIMEOUT) ? tcnt : tcnt + 1'b1;
        if (tr_end) begin
          start_d = 1'b0;
          ok_d = ~ack;
          state_d = ST_WAIT_LOW;
        end else if (tcnt_d == TW'(TIMEOUT)) begin
          start_d = 1'b0;
          ok_d = 1'b0;
          state_d = ST_WAIT_LOW;
        end
      end
      // holding here until the engine releases tr_end keeps start from rising on a stale tr_end
      ST_WAIT_LOW: if (!tr_end) begin
        gcnt_d = '0;
        state_d = ST_GAP;
        if (ok || rcnt == RW'(MAX_RETRY)) begin
          rsp_done_d = grant_id ? 2'b10 : 2'b01;
          rsp_err_d = ~ok;
          pend_d = 1'b0;
        end else begin
          rcnt_d = rcnt + 1'b1;
          pend_d = 1'b1;
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt + 1'b1;
        if (gcnt == GW'(GAP - 1)) begin
          state_d = pend ? ST_LAUNCH : ST_IDLE;
          busy_d = pend;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock_i2c or negedge camera_rstn)
    if (!camera_rstn) begin
      state <= ST_IDLE;
      tcnt <= '0;
      rcnt <= '0;
      gcnt <= '0;
      ok <= 1'b0;
      pend <= 1'b0;
      i2c_data <= '0;
      grant_id <= 1'b0;
      start <= 1'b0;
      busy <= 1'b0;
      req_ready <= '0;
      rsp_done <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_d;
      tcnt <= tcnt_d;
      rcnt <= rcnt_d;
      gcnt <= gcnt_d;
      ok <= ok_d;
      pend <= pend_d;
      i2c_data <= i2c_data_d;
      grant_id <= grant_id_d;
      start <= start_d;
      busy <= busy_d;
      req_ready <= req_ready_d;
      rsp_done <= rsp_done_d;
      rsp_err <= rsp_err_d;
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed stimulus with a scoreboard monitor and a behavioural I2C engine for i2c_arbiter
module tb_i2c_arbiter;
  typedef struct packed {logic [1:0] rdy; logic [31:0] data;} acc_t;
  logic clk = 1'b0;
  logic rstn, v0, v1, rsp_err, start, tr_end, ack, busy, grant_id;
  logic [31:0] req0_data, req1_data, i2c_data;
  logic [1:0] req_valid, req_ready, rsp_done;
  int tests = 0, fails = 0, cyc = 0, done_seen = 0;
  int eng_delay = 10, eng_hold = 0;
  bit eng_ack = 1'b0, eng_never = 1'b0;
  int rdy_seen[2] = '{0, 0};
  acc_t acc_q[$];
  logic [2:0] rsp_q[$];
  int gaps[$], lens[$];
  assign req_valid = {v1, v0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  i2c_arbiter dut (
    .clock_i2c(clk), .camera_rstn(rstn), .req_valid(req_valid),
    .req0_data(req0_data), .req1_data(req1_data), .req_ready(req_ready),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .i2c_data(i2c_data),
    .start(start), .tr_end(tr_end), .ack(ack), .busy(busy), .grant_id(grant_id)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic wait_ready(input int id, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[id] && n < budget);
    if (!req_ready[id]) begin
      tests++; fails++;
      $display("FAIL ready_timeout: requester %0d saw no ready within %0d cycles", id, budget);
    end
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (rsp_done == 2'b00 && n < budget);
    if (rsp_done == 2'b00) begin
      tests++; fails++;
      $display("FAIL done_timeout: no rsp_done within %0d cycles", budget);
    end
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || rsp_q.size() != 0) && n < budget);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_pending", rsp_q.size(), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic drive3(input int id);
    for (int k = 0; k < 3; k++) begin
      if (id == 0) begin req0_data = 32'hA000_0000 + k; v0 = 1'b1; end
      else begin req1_data = 32'hB100_0000 + k; v1 = 1'b1; end
      wait_ready(id, 400);
    end
    if (id == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask
  // engine: raises tr_end eng_delay cycles after start, keeps it eng_hold cycles after start drops
  initial begin
    int n, h;
    bit serving;
    serving = 1'b0; n = 0; h = 0;
    tr_end = 1'b0; ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!serving && start && !tr_end) begin serving = 1'b1; n = 0; h = 0; end
      else if (serving && !start) begin
        if (h >= eng_hold) begin tr_end = 1'b0; ack = 1'b0; serving = 1'b0; end
        else h++;
      end else if (serving && !eng_never && !tr_end) begin
        n++;
        if (n >= eng_delay) begin tr_end = 1'b1; ack = eng_ack; end
      end
    end
  end
  // monitor: pops the scoreboard whenever the DUT pulses ready or done, and logs start timing
  initial begin
    acc_t e;
    logic [2:0] r;
    logic ps;
    int rise_c, fall_c;
    ps = 1'b0; rise_c = 0; fall_c = 0;
    forever begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        if (req_ready[0]) rdy_seen[0]++;
        if (req_ready[1]) rdy_seen[1]++;
        if (acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ready: got %b expected none", req_ready);
        end else begin
          e = acc_q.pop_front();
          chk("ready", req_ready, e.rdy);
          chk("grant_id", grant_id, e.rdy[1]);
          chk("i2c_data", i2c_data, e.data);
        end
      end
      if (rsp_done != 2'b00) begin
        done_seen++;
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got %b err %b expected none", rsp_done, rsp_err);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_done", rsp_done, r[2:1]);
          chk("rsp_err", rsp_err, r[0]);
        end
      end
      if (start && !ps) begin
        chk("start_while_tr_end", tr_end, 0);
        gaps.push_back(cyc - fall_c);
        rise_c = cyc;
      end
      if (!start && ps) begin
        lens.push_back(cyc - rise_c);
        fall_c = cyc;
      end
      ps = start;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int g0, l0, r1, d0;
    rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; req0_data = '0; req1_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i2c_data", i2c_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", rsp_done, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_grant", grant_id, 0);
    rstn = 1'b1;
    // both requesters, three back-to-back each: strict alternation starting at 0
    eng_delay = 5; eng_ack = 1'b0; eng_hold = 0;
    for (int k = 0; k < 3; k++) begin
      acc_q.push_back({2'b01, 32'hA000_0000 + k});
      acc_q.push_back({2'b10, 32'hB100_0000 + k});
      rsp_q.push_back(3'b010);
      rsp_q.push_back(3'b100);
    end
    @(negedge clk);
    fork
      drive3(0);
      drive3(1);
    join
    wait_idle(400);
    // single req0, ack after 40 cycles
    eng_delay = 40;
    acc_q.push_back({2'b01, 32'h7830_0882});
    rsp_q.push_back(3'b010);
    g0 = gaps.size();
    req0_data = 32'h7830_0882; v0 = 1'b1;
    wait_ready(0, 20);
    v0 = 1'b0;
    chk("t1_busy_accept", busy, 1);
    chk("t1_start_pre", start, 0);
    @(negedge clk);
    chk("t1_start_launch", start, 1);
    wait_done(200);
    chk("t1_busy_done", busy, 1);
    @(negedge clk);
    chk("t1_busy_gap", busy, 1);
    @(negedge clk);
    chk("t1_busy_after_gap", busy, 0);
    chk("t1_attempts", gaps.size() - g0, 1);
    // req1 with NACK every time, engine holds tr_end after start drops
    eng_delay = 10; eng_ack = 1'b1; eng_hold = 5;
    acc_q.push_back({2'b10, 32'h4200_1234});
    rsp_q.push_back(3'b101);
    g0 = gaps.size();
    @(negedge clk);
    req1_data = 32'h4200_1234; v1 = 1'b1;
    wait_ready(1, 20);
    v1 = 1'b0;
    wait_done(500);
    chk("t3_attempts", gaps.size() - g0, 3);
    for (int i = g0 + 1; i < gaps.size(); i++) chk("t3_gap_ge2", gaps[i] >= 2, 1);
    wait_idle(100);
    // engine never answers: three timeouts of TIMEOUT cycles each
    eng_never = 1'b1; eng_ack = 1'b0; eng_hold = 0;
    acc_q.push_back({2'b01, 32'h3012_3455});
    rsp_q.push_back(3'b011);
    g0 = gaps.size(); l0 = lens.size();
    req0_data = 32'h3012_3455; v0 = 1'b1;
    wait_ready(0, 20);
    v0 = 1'b0;
    wait_done(5000);
    chk("t4_attempts", gaps.size() - g0, 3);
    chk("t4_lens", lens.size() - l0, 3);
    for (int i = l0; i < lens.size(); i++) chk("t4_start_len", lens[i], 1023);
    wait_idle(100);
    // reset while waiting for tr_end aborts silently
    acc_q.push_back({2'b01, 32'h1234_5678});
    req0_data = 32'h1234_5678; v0 = 1'b1;
    wait_ready(0, 20);
    v0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_start_before", start, 1);
    d0 = done_seen;
    #2 rstn = 1'b0;
    #1;
    chk("t5_start_async", start, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_data_async", i2c_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    eng_never = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_no_done", done_seen - d0, 0);
    eng_delay = 8;
    acc_q.push_back({2'b01, 32'h5A00_11C3});
    rsp_q.push_back(3'b010);
    req0_data = 32'h5A00_11C3; v0 = 1'b1;
    wait_ready(0, 20);
    v0 = 1'b0;
    wait_done(200);
    wait_idle(100);
    // req1 withdrawn while req0 is serviced
    eng_delay = 30;
    acc_q.push_back({2'b01, 32'h6677_8899});
    rsp_q.push_back(3'b010);
    r1 = rdy_seen[1]; g0 = gaps.size();
    req0_data = 32'h6677_8899; v0 = 1'b1;
    wait_ready(0, 20);
    v0 = 1'b0;
    @(negedge clk);
    req1_data = 32'hDEAD_BEEF; v1 = 1'b1;
    repeat (10) @(negedge clk);
    v1 = 1'b0;
    wait_done(200);
    repeat (20) @(negedge clk);
    chk("t6_no_ready1", rdy_seen[1] - r1, 0);
    chk("t6_attempts", gaps.size() - g0, 1);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter MAX_RETRY, default 2: extra attempts after a failed attempt (NACK or timeout); total attempts = MAX_RETRY+1.
REQ-002 Parameter TIMEOUT, default 1023: clock_i2c cycles allowed from start rising to tr_end.
REQ-003 Parameter GAP, default 2: idle cycles enforced between engine transactions (including retries).
REQ-004 clock_i2c  input  1  single clock (I2C engine clock); every register of the block is on its rising edge.
REQ-005 camera_rstn  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  2  per-requester request; bit 0 = boot config sequencer, bit 1 = runtime register writer.
REQ-007 req0_data, req1_data  input  32 each  {device addr[31:24], reg addr[23:8], reg data[7:0]}.
REQ-008 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-009 rsp_done  output  2  one-cycle completion pulse to the owning requester.
REQ-010 rsp_err  output  1  valid only with rsp_done; 1 = all attempts failed.
REQ-011 i2c_data  output  32  word driven to the engine; start  output  1  engine start; tr_end  input  1  engine transfer end; ack  input  1  engine NACK flag (1 = NACK), sampled with tr_end.
REQ-012 busy  output  1  high from accept through end of GAP; grant_id  output  1  index of current owner.

Function
REQ-013 FSM states SHALL be IDLE, LAUNCH, WAIT_END, WAIT_LOW, GAP; all outputs registered.
REQ-014 Arbitration in IDLE SHALL be two-way round robin: single valid wins; both valid -> the one not last served; after reset requester 0 wins ties.
REQ-015 On a win, req_ready[winner] SHALL pulse for one cycle, i2c_data/grant_id SHALL latch the winner's data, FSM -> LAUNCH.
REQ-016 Requester SHALL hold data stable while valid until ready; valid dropped before ready is a withdrawn request, no transaction, no rsp_done.
REQ-017 LAUNCH: start<=1, timeout counter cleared, -> WAIT_END; start rises 2 cycles after valid is first sampled in IDLE.
REQ-018 WAIT_END: tr_end=1 -> start<=0, attempt fails if ack=1 else succeeds; counter reaching TIMEOUT first -> start<=0, attempt fails; -> WAIT_LOW.
REQ-019 WAIT_LOW: wait for tr_end=0 (engine release); then success or attempts exhausted -> rsp_done[grant_id] pulse with rsp_err, -> GAP; otherwise retry counter +1 -> GAP with retry pending.
REQ-020 GAP: count GAP cycles, then -> LAUNCH if retry pending (same i2c_data, no re-arbitration), else -> IDLE and busy<=0.
REQ-021 Timeout counter width clog2(TIMEOUT+1), saturating; retry counter width clog2(MAX_RETRY+1), cleared on each accept.
REQ-022 start SHALL never be reasserted while tr_end=1; at most one transaction outstanding.
REQ-023 Requests arriving while busy SHALL wait; last-served pointer updates only on accept.

Reset
REQ-024 camera_rstn low SHALL immediately force IDLE, start=0, i2c_data=0, req_ready=0, rsp_done=0, rsp_err=0, busy=0, grant_id=0, counters 0, pointer favours requester 0.
REQ-025 Reset mid-transaction SHALL abort silently: no rsp_done for the aborted request.

Structure
REQ-026 Shared package i2c_arb_pkg SHALL hold FSM state encodings, requester index constants (REQ_BOOT=0, REQ_RT=1), field slice constants and parameter defaults.
REQ-027 One sub-module rr_arbiter2 SHALL implement the two-way round-robin pointer and grant decode.

Verification
REQ-028 Only req0 valid with 0x78300882, engine returns tr_end after 40 cycles with ack=0 -> ready[0] pulse, i2c_data=0x78300882, rsp_done[0] with rsp_err=0, busy low after GAP.
REQ-029 Both valid simultaneously, three back-to-back transactions each -> grant order 0,1,0,1,0,1.
REQ-030 req1 with ack=1 on every tr_end -> exactly 3 start pulses each separated by >=2 idle cycles, then rsp_done[1] with rsp_err=1.
REQ-031 Engine never asserts tr_end -> start drops 1023 cycles after rising, 3 attempts total, rsp_err=1.
REQ-032 camera_rstn pulsed low during WAIT_END -> start=0 immediately, no rsp_done; fresh req0 after reset completes normally.
REQ-033 req1 valid dropped before ready while req0 being serviced -> no transaction for req1, no rsp_done[1].
